// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button synchronise/debounce, start/stop/lap/reset FSM,
// count-enable gating and display mux. Optional auto-stop on 99 via STOPWATCH_AUTOSTOP_EN.
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20
) (
    input  logic       clk_50MHz,
    input  logic       clr,
    input  logic       ss_btn,
    input  logic       lr_btn,
    input  logic       tick_in,
    input  logic [3:0] high_in,
    input  logic [3:0] low_in,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [3:0] disp_high,
    output logic [3:0] disp_low,
    output logic       running,
    output logic       lap_active,
    output logic       ovf
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam int BTN_SS = 0;
    localparam int BTN_LR = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_PAUSE
    } state_e;

    // ------------------------------------------------------------------
    // Button path: both buttons share the same logic, indexed by BTN_*
    // ------------------------------------------------------------------
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       stable_q, stable_d;
    logic [1:0]       press_q, press_d;
    logic [DEB_W-1:0] deb_cnt_q [2];
    logic [DEB_W-1:0] deb_cnt_d [2];

    assign btn_raw = {lr_btn, ss_btn};

    // NOTE: every *_d gets its hold/default value first, so no path through
    // a combinational block can leave a signal unassigned and infer a latch.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        for (int b = 0; b < 2; b++) begin
            stable_d[b]  = stable_q[b];
            deb_cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (deb_cnt_q[b] == DEB_LAST) begin
                    stable_d[b] = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
                end
            end
        end
        press_d = stable_d & ~stable_q;
    end

    logic ss_evt;
    logic lr_evt;

    assign ss_evt = press_q[BTN_SS];
    assign lr_evt = press_q[BTN_LR];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic       cnt_en_q, cnt_en_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic [3:0] lap_high_q, lap_high_d;
    logic [3:0] lap_low_q, lap_low_d;
    logic       run_like;
    logic       ss_blocked;

    assign run_like = (state_q == S_RUN) || (state_q == S_LAP);

`ifdef STOPWATCH_AUTOSTOP_EN
    logic ovf_q, ovf_d;
    logic at_max;

    assign at_max     = (high_in == 4'd9) && (low_in == 4'd9);
    assign ss_blocked = ovf_q;
`else
    assign ss_blocked = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        lap_high_d = lap_high_q;
        lap_low_d  = lap_low_q;
        cnt_clr_d  = 1'b0;
        // State is sampled before the transition, so a tick coincident with
        // a stop event still counts.
        cnt_en_d   = tick_in && run_like;
`ifdef STOPWATCH_AUTOSTOP_EN
        ovf_d      = ovf_q;
`endif

        // ss has priority: when it fires, a simultaneous lr is dropped.
        unique case (state_q)
            S_IDLE: begin
                if (ss_evt) begin
                    state_d = S_RUN;
                end else if (lr_evt) begin
                    cnt_clr_d = 1'b1;
                end
            end
            S_RUN: begin
                if (ss_evt) begin
                    state_d = S_PAUSE;
                end else if (lr_evt) begin
                    state_d    = S_LAP;
                    lap_high_d = high_in;
                    lap_low_d  = low_in;
                end
            end
            S_LAP: begin
                if (ss_evt) begin
                    state_d = S_PAUSE;
                end else if (lr_evt) begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (ss_evt) begin
                    if (!ss_blocked) begin
                        state_d = S_RUN;
                    end
                end else if (lr_evt) begin
                    state_d   = S_IDLE;
                    cnt_clr_d = 1'b1;
`ifdef STOPWATCH_AUTOSTOP_EN
                    ovf_d     = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef STOPWATCH_AUTOSTOP_EN
        // Counting past 99 is refused: the tick is swallowed and the watch stops.
        if (tick_in && run_like && at_max) begin
            cnt_en_d = 1'b0;
            state_d  = S_PAUSE;
            ovf_d    = 1'b1;
        end
`endif
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_50MHz) begin
        if (clr) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            press_q    <= '0;
            deb_cnt_q  <= '{default: '0};
            state_q    <= S_IDLE;
            cnt_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b0;
            lap_high_q <= '0;
            lap_low_q  <= '0;
`ifdef STOPWATCH_AUTOSTOP_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            press_q    <= press_d;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            cnt_en_q   <= cnt_en_d;
            cnt_clr_q  <= cnt_clr_d;
            lap_high_q <= lap_high_d;
            lap_low_q  <= lap_low_d;
`ifdef STOPWATCH_AUTOSTOP_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cnt_en     = cnt_en_q;
    assign cnt_clr    = cnt_clr_q;
    assign running    = run_like;
    assign lap_active = (state_q == S_LAP);
    assign disp_high  = lap_active ? lap_high_q : high_in;
    assign disp_low   = lap_active ? lap_low_q  : low_in;

`ifdef STOPWATCH_AUTOSTOP_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
